// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin front end that lets two requesters share
// one combinational unsigned multiplier, one transaction in flight at a time.
//
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_reqN_valid / o_reqN_ready      operand handshake for requester N (0,1)
//   i_reqN_a, i_reqN_b [BIT-1:0]     operands for requester N
//   o_rsp_valid / i_rsp_ready        result handshake
//   o_rsp_out [2*BIT-1:0]            registered product
//   o_rsp_id                         requester that issued the result
//
// FSM states:
//   state  | meaning
//   S_IDLE | waiting for a request; readies follow the round-robin grant
//   S_MUL  | operands latched, multiplier settling on r_op_a * r_op_b
//   S_RESP | result registered, held until the consumer takes it

// Plain combinational unsigned multiplier shared by the arbiter.
//   i_a, i_b [W-1:0] operands, o_p [2*W-1:0] full-width product
module multiplier #(
  parameter int W = 4
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);
  assign o_p = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
endmodule

module mult_share_arbiter #(
  parameter int BIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [BIT-1:0]   i_req0_a,
  input  logic [BIT-1:0]   i_req0_b,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [BIT-1:0]   i_req1_a,
  input  logic [BIT-1:0]   i_req1_b,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [2*BIT-1:0] o_rsp_out,
  output logic             o_rsp_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;
  logic [BIT-1:0]   r_op_a;
  logic [BIT-1:0]   r_op_b;
  logic             r_op_id;
  logic             r_rsp_valid;
  logic [2*BIT-1:0] r_rsp_out;
  logic             r_rsp_id;

  logic             w_grant_vld;
  logic             w_grant_id;
  logic             w_accept;
  logic [2*BIT-1:0] w_prod;

  multiplier #(.W(BIT)) u_mult (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_prod)
  );

  // Round-robin grant: on contention the requester that did not win last time
  // gets it; the grant already implies the winner's valid is high.
  always_comb begin
    w_grant_vld = i_req0_valid | i_req1_valid;
    w_grant_id  = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      w_grant_id = ~r_last;
    end else if (i_req1_valid) begin
      w_grant_id = 1'b1;
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_grant_vld;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_state_nxt = S_MUL;
      S_MUL:   w_state_nxt = S_RESP;
      S_RESP:  if (r_rsp_valid && i_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: readies depend only on state, last winner and the valids.
  always_comb begin
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    if (r_state == S_IDLE && w_grant_vld) begin
      o_req0_ready = ~w_grant_id;
      o_req1_ready = w_grant_id;
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last      <= 1'b1;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_id     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_out   <= '0;
      r_rsp_id    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_a  <= w_grant_id ? i_req1_a : i_req0_a;
        r_op_b  <= w_grant_id ? i_req1_b : i_req0_b;
        r_op_id <= w_grant_id;
        r_last  <= w_grant_id;
      end
      if (r_state == S_MUL) begin
        r_rsp_out   <= w_prod;
        r_rsp_id    <= r_op_id;
        r_rsp_valid <= 1'b1;
      end else if (r_state == S_RESP && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_out   = r_rsp_out;
  assign o_rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit DUT
  logic       rst, v0, v1, rr;
  logic [3:0] a0, b0, a1, b1;
  logic       rdy0, rdy1, rsp_valid, rsp_id;
  logic [7:0] rsp_out;

  // 8-bit DUT
  logic        rst8, v08, rr8;
  logic [7:0]  a08, b08;
  logic        rdy08, rdy18, rsp_valid8, rsp_id8;
  logic [15:0] rsp_out8;

  mult_share_arbiter #(.BIT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_a(a0), .i_req0_b(b0),
    .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_a(a1), .i_req1_b(b1),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rr), .o_rsp_out(rsp_out), .o_rsp_id(rsp_id)
  );

  mult_share_arbiter #(.BIT(8)) dut8 (
    .i_clk(clk), .i_rst(rst8),
    .i_req0_valid(v08), .o_req0_ready(rdy08), .i_req0_a(a08), .i_req0_b(b08),
    .i_req1_valid(1'b0), .o_req1_ready(rdy18), .i_req1_a(8'd0), .i_req1_b(8'd0),
    .o_rsp_valid(rsp_valid8), .i_rsp_ready(rr8), .o_rsp_out(rsp_out8), .o_rsp_id(rsp_id8)
  );

  int n_chk = 0;
  int n_err = 0;

  // Transaction-level reference: phase 0 = free, 1 = computing, 2 = result held.
  int         m_phase = 0;
  bit         m_last = 1'b1;
  logic [7:0] m_out = 8'd0, m_prod = 8'd0;
  bit         m_id = 1'b0, m_nid = 1'b0;

  // Per-step observations
  bit         acc, acc_id, hs;
  logic [7:0] got_out;
  bit         got_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step(input bit rs, input bit q0, input logic [3:0] x0, input logic [3:0] y0,
                      input bit q1, input logic [3:0] x1, input logic [3:0] y1, input bit rdy);
    bit gv, gid;
    @(negedge clk);
    rst = rs; v0 = q0; a0 = x0; b0 = y0; v1 = q1; a1 = x1; b1 = y1; rr = rdy;
    #1;
    gv  = q0 | q1;
    gid = (q0 && q1) ? ~m_last : (q1 && !q0);
    chk("req0_ready", rdy0, (m_phase == 0) && gv && !gid);
    chk("req1_ready", rdy1, (m_phase == 0) && gv && gid);
    chk("rsp_valid", rsp_valid, m_phase == 2);
    chk("rsp_out", rsp_out, m_out);
    chk("rsp_id", rsp_id, m_id);
    acc = 0; hs = 0;
    if (rs) begin
      m_phase = 0; m_last = 1; m_out = 0; m_id = 0;
    end else begin
      case (m_phase)
        0: if (gv) begin
             acc = 1; acc_id = gid; m_last = gid; m_nid = gid; m_phase = 1;
             m_prod = gid ? 8'(x1) * 8'(y1) : 8'(x0) * 8'(y0);
           end
        1: begin m_out = m_prod; m_id = m_nid; m_phase = 2; end
        default: if (rdy) begin hs = 1; got_out = rsp_out; got_id = rsp_id; m_phase = 0; end
      endcase
    end
  endtask

  task automatic idle(input bit rs);
    step(rs, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Single transaction from one requester; bounded waits on accept and response.
  task automatic do_txn(input bit id, input logic [3:0] x, input logic [3:0] y);
    int k;
    k = 0;
    do begin
      step(0, !id, x, y, id, x, y, 1);
      k++;
    end while (!acc && k < 10);
    if (!acc) chk("txn_accept_timeout", 0, 1);
    k = 0;
    do begin
      step(0, 0, 0, 0, 0, 0, 0, 1);
      k++;
    end while (!hs && k < 10);
    if (!hs) chk("txn_resp_timeout", 0, 1);
  endtask

  int         ids[$];
  logic [7:0] outs[$];
  bit         p0, p1;
  logic [3:0] pa0, pb0, pa1, pb1;
  int         k;

  initial begin
    rst = 1; v0 = 0; v1 = 0; rr = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    rst8 = 1; v08 = 0; rr8 = 0; a08 = 0; b08 = 0;

    // Reset, then basic req0 transaction 3*5
    idle(1); idle(1);
    step(0, 1, 4'd3, 4'd5, 0, 0, 0, 0);
    chk("t1_accept", acc, 1);
    chk("t1_acc_id", acc_id, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("t1_hs", hs, 1);
    chk("t1_out", got_out, 15);
    chk("t1_id", got_id, 0);
    idle(0);

    // Contention from reset: grants must go 0,1,0
    idle(1);
    ids.delete(); outs.delete();
    k = 0;
    while (ids.size() < 3 && k < 30) begin
      step(0, 1, 4'd15, 4'd15, 1, 4'd2, 4'd7, 1);
      if (acc) ids.push_back(acc_id);
      if (hs) outs.push_back(got_out);
      k++;
    end
    chk("t2_grant_count", ids.size(), 3);
    if (ids.size() == 3) begin
      chk("t2_grant0", ids[0], 0);
      chk("t2_grant1", ids[1], 1);
      chk("t2_grant2", ids[2], 0);
    end
    chk("t2_resp_count", outs.size(), 2);
    if (outs.size() == 2) begin
      chk("t2_out0", outs[0], 225);
      chk("t2_out1", outs[1], 14);
    end

    // Backpressure: req1 (9,0) held in RESP for 5 cycles while req0 waits
    idle(1);
    step(0, 0, 0, 0, 1, 4'd9, 4'd0, 0);
    chk("t3_acc_id", acc_id, 1);
    step(0, 1, 4'd4, 4'd4, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 4'd4, 4'd4, 0, 0, 0, 0);
    step(0, 1, 4'd4, 4'd4, 0, 0, 0, 1);
    chk("t3_hs", hs, 1);
    chk("t3_out", got_out, 0);
    chk("t3_id", got_id, 1);
    step(0, 1, 4'd4, 4'd4, 0, 0, 0, 1);
    chk("t3_req0_after", acc, 1);
    idle(0); idle(0); idle(0);

    // Boundary operands
    do_txn(0, 4'd15, 4'd15); chk("b_15x15", got_out, 225);
    do_txn(1, 4'd0,  4'd15); chk("b_0x15",  got_out, 0);
    do_txn(0, 4'd1,  4'd8);  chk("b_1x8",   got_out, 8);
    do_txn(1, 4'd8,  4'd2);  chk("b_8x2",   got_out, 16);

    // Reset while in MUL: req0 won last, so without reset req1 would win next
    step(0, 1, 4'd7, 4'd7, 0, 0, 0, 1);
    chk("r1_acc_id", acc_id, 0);
    idle(1);
    step(0, 1, 4'd2, 4'd3, 1, 4'd3, 4'd3, 1);
    chk("r1_rsp_valid_zero", rsp_valid, 0);
    chk("r1_rsp_out_zero", rsp_out, 0);
    chk("r1_contention_id", acc_id, 0);
    idle(0); idle(0); idle(0);

    // Reset while in RESP
    step(0, 1, 4'd5, 4'd5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4'd2, 4'd3, 1, 4'd3, 4'd3, 0);
    chk("r2_rsp_valid_zero", rsp_valid, 0);
    chk("r2_rsp_out_zero", rsp_out, 0);
    chk("r2_contention_id", acc_id, 0);
    idle(0); idle(0); idle(0);

    // Late request: req1 rises during RESP
    step(0, 1, 4'd6, 4'd2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4'd13, 4'd11, 0);
    step(0, 0, 0, 0, 1, 4'd13, 4'd11, 0);
    step(0, 0, 0, 0, 1, 4'd13, 4'd11, 1);
    chk("l_hs", hs, 1);
    chk("l_out0", got_out, 12);
    step(0, 0, 0, 0, 1, 4'd13, 4'd11, 1);
    chk("l_acc", acc, 1);
    chk("l_acc_id", acc_id, 1);
    idle(0);
    idle(0);
    chk("l_out1", got_out, 143);
    chk("l_id1", got_id, 1);

    // Randomized traffic against the model
    p0 = 0; p1 = 0; pa0 = 0; pb0 = 0; pa1 = 0; pb1 = 0;
    for (int i = 0; i < 600; i++) begin
      bit r;
      r = ($urandom_range(0, 79) == 0);
      step(r, p0, pa0, pb0, p1, pa1, pb1, $urandom_range(0, 3) != 0);
      if (acc) begin
        if (acc_id) p1 = 0; else p0 = 0;
      end
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1; pa0 = 4'($urandom); pb0 = 4'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1; pa1 = 4'($urandom); pb1 = 4'($urandom);
      end
    end
    idle(1);

    // 8-bit instance: 255*255
    @(negedge clk); rst8 = 1;
    @(negedge clk); rst8 = 0; v08 = 1; a08 = 8'd255; b08 = 8'd255; rr8 = 0;
    #1 chk("w8_ready", rdy08, 1);
    @(negedge clk); v08 = 0;
    k = 0;
    while (!rsp_valid8 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("w8_rsp_valid", rsp_valid8, 1);
    chk("w8_out", rsp_out8, 65025);
    chk("w8_id", rsp_id8, 0);
    rr8 = 1;
    @(negedge clk); rr8 = 0;
    chk("w8_rsp_cleared", rsp_valid8, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
